// File: rtl/bcd_counter_chain.sv
// Multi-digit modulo-MODULUS up/down counter with clear, clamped parallel load,
// combinational terminal count and a registered one-cycle wrap pulse.
module bcd_counter_chain #(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                carry_out
);

  localparam logic [3:0] MAX_DIGIT = 4'(MODULUS - 1);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                carry_q, carry_d;
  logic [DIGITS-1:0]   step_up, step_dn;

  // step_up[k] / step_dn[k]: every digit below k is at max / at zero,
  // so digit k moves on this edge; the final prefix is the terminal count.
  always_comb begin
    logic all_max;
    logic all_zero;
    all_max  = 1'b1;
    all_zero = 1'b1;
    step_up  = '0;
    step_dn  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      step_up[k] = all_max;
      step_dn[k] = all_zero;
      all_max    = all_max  & (count_q[4*k +: 4] == MAX_DIGIT);
      all_zero   = all_zero & (count_q[4*k +: 4] == 4'd0);
    end
    tc = up ? all_max : all_zero;
  end

  // NOTE: every output of this block is assigned a default first, so no
  // path through the if/else chain can leave a latch behind.
  always_comb begin
    logic [3:0] digit;
    count_d = count_q;
    carry_d = 1'b0;
    digit   = '0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      for (int k = 0; k < DIGITS; k++) begin
        digit             = load_val[4*k +: 4];
        count_d[4*k +: 4] = (digit > MAX_DIGIT) ? MAX_DIGIT : digit;
      end
    end else if (en) begin
      carry_d = tc;
      for (int k = 0; k < DIGITS; k++) begin
        digit = count_q[4*k +: 4];
        if (up && step_up[k]) begin
          count_d[4*k +: 4] = (digit == MAX_DIGIT) ? 4'd0 : digit + 4'd1;
        end else if (!up && step_dn[k]) begin
          count_d[4*k +: 4] = (digit == 4'd0) ? MAX_DIGIT : digit - 4'd1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign count     = count_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Randomised and directed bench for bcd_counter_chain: three instances
// (2-digit decimal, 2-digit modulo-6, 4-digit decimal) share one stimulus.
module tb_bcd_counter_chain;

  logic        clk = 1'b0;
  logic        rst, en, up, clr, load;
  logic [15:0] load_val;

  logic [7:0]  cnt_a, cnt_b;
  logic [15:0] cnt_c;
  logic        tc_a, tc_b, tc_c, carry_a, carry_b, carry_c;

  int checks = 0;
  int errors = 0;

  // Reference model: each instance's count kept as a plain integer in 0..MODULUS**DIGITS-1.
  int   mods [3] = '{10, 6, 10};
  int   digs [3] = '{2, 2, 4};
  int   mv   [3];
  logic mc   [3];

  always #5 clk = ~clk;

  bcd_counter_chain #(.DIGITS(2), .MODULUS(10)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val[7:0]), .count(cnt_a), .tc(tc_a), .carry_out(carry_a));

  bcd_counter_chain #(.DIGITS(2), .MODULUS(6)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val[7:0]), .count(cnt_b), .tc(tc_b), .carry_out(carry_b));

  bcd_counter_chain dut_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_c), .tc(tc_c), .carry_out(carry_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int span(input int i);
    int n = 1;
    for (int k = 0; k < digs[i]; k++) n *= mods[i];
    return n;
  endfunction

  function automatic logic [15:0] to_digits(input int v, input int m, input int d);
    logic [15:0] r = '0;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(v % m);
      v = v / m;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv, input int m, input int d);
    int acc = 0;
    int f;
    for (int k = d - 1; k >= 0; k--) begin
      f = int'(lv[4*k +: 4]);
      if (f >= m) f = m - 1;
      acc = acc * m + f;
    end
    return acc;
  endfunction

  function automatic logic model_tc(input int i);
    return up ? (mv[i] == span(i) - 1) : (mv[i] == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0;
      mc[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int n;
    for (int i = 0; i < 3; i++) begin
      n = span(i);
      if (rst || clr) begin
        mv[i] = 0;
        mc[i] = 1'b0;
      end else if (load) begin
        mv[i] = from_load(load_val, mods[i], digs[i]);
        mc[i] = 1'b0;
      end else if (en) begin
        mc[i] = model_tc(i);
        mv[i] = up ? (mv[i] + 1) % n : (mv[i] + n - 1) % n;
      end else begin
        mc[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] got_cnt [3];
    logic        got_tc  [3];
    logic        got_cy  [3];
    got_cnt = '{{8'h00, cnt_a}, {8'h00, cnt_b}, cnt_c};
    got_tc  = '{tc_a, tc_b, tc_c};
    got_cy  = '{carry_a, carry_b, carry_c};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.count[%0d]", tag, i), got_cnt[i], to_digits(mv[i], mods[i], digs[i]));
      check($sformatf("%s.tc[%0d]", tag, i), got_tc[i], model_tc(i));
      check($sformatf("%s.carry[%0d]", tag, i), got_cy[i], mc[i]);
    end
  endtask

  // One rising edge; the model advances on the same edge, outputs are compared mid-low-phase.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    cycle("reset_hold");
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Up count through 99 to wrap on the decimal pair
    en = 1'b1; up = 1'b1;
    repeat (99) cycle("up");
    check("up99.count", cnt_a, 8'h99);
    check("up99.tc", tc_a, 1'b1);
    cycle("up");
    check("up100.count", cnt_a, 8'h00);
    check("up100.carry", carry_a, 1'b1);
    cycle("up");
    check("up101.carry", carry_a, 1'b0);

    // Modulo-6 sequence: 05 -> 10 without carry, 55 -> 00 with carry
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int e = 1; e <= 36; e++) begin
      cycle("mod6");
      if (e == 5)  check("mod6.05", cnt_b, 8'h05);
      if (e == 6)  begin check("mod6.10", cnt_b, 8'h10); check("mod6.10.carry", carry_b, 1'b0); end
      if (e == 35) check("mod6.55", cnt_b, 8'h55);
      if (e == 36) begin check("mod6.00", cnt_b, 8'h00); check("mod6.00.carry", carry_b, 1'b1); end
    end

    // Down wrap from zero
    do_reset();
    en = 1'b0; up = 1'b0;
    #1 check("down.tc0", tc_a, 1'b1);
    en = 1'b1;
    cycle("down");
    check("down.99", cnt_a, 8'h99);
    check("down.99.carry", carry_a, 1'b1);
    cycle("down");
    check("down.98", cnt_a, 8'h98);
    check("down.98.carry", carry_a, 1'b0);

    // Load beats enable, then clamp out-of-range digits
    up = 1'b1; load = 1'b1; load_val = 16'h0037;
    cycle("load");
    check("load.37", cnt_a, 8'h37);
    load = 1'b0;
    cycle("load");
    check("load.38", cnt_a, 8'h38);
    load = 1'b1; load_val = 16'h00AF;
    cycle("load");
    check("load.clamp", cnt_a, 8'h99);
    check("load.clamp.tc", tc_a, 1'b1);
    up = 1'b0;
    #1 check("dirchange.tc", tc_a, 1'b0);
    up = 1'b1;

    // Clear outranks load and enable; enable low holds
    load_val = 16'h0042;
    cycle("prio");
    clr = 1'b1; load_val = 16'h0055; en = 1'b1;
    cycle("prio");
    check("prio.clr", cnt_a, 8'h00);
    clr = 1'b0; load_val = 16'h0042;
    cycle("prio");
    load = 1'b0; en = 1'b0;
    repeat (5) cycle("hold");
    check("hold.42", cnt_a, 8'h42);
    check("hold.carry", carry_a, 1'b0);

    // Asynchronous reset between edges
    load = 1'b1; load_val = 16'h0057;
    cycle("async");
    load = 1'b0;
    check("async.57", cnt_a, 8'h57);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async.cleared", cnt_a, 8'h00);
    check("async.carry", carry_a, 1'b0);
    en = 1'b1;
    cycle("async_hold");
    check("async.held", cnt_a, 8'h00);
    rst = 1'b0;

    // Randomised traffic against the model
    repeat (2000) begin
      rst      = ($urandom_range(0, 149) == 0);
      clr      = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 19) == 0);
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) up = ~up;
      load_val = 16'($urandom);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
